if_fetch_unit: RTL and testbench

//  Fetch stage of the 5-stage RV32 pipeline. Replaces the bare pc_reg + combinational inst_mem pair.

---
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// fetch-to-decode handshake. "master" is the fetch unit, "slave" is memory + IF/ID.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  fd_valid;
    logic                  fd_ready;
    logic [ADDR_WIDTH-1:0] fd_pc;
    logic [DATA_WIDTH-1:0] fd_inst;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output fd_valid, fd_pc, fd_inst,
        input  fd_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  fd_valid, fd_pc, fd_inst,
        output fd_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32 fetch stage: issues PC requests to a latency-tolerant instruction memory and
// buffers returned {pc,inst} pairs in an in-order FIFO feeding the IF/ID register.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    if_fetch_unit_if.master       bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((FCW > CW) ? FCW : CW) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         discard;
    logic [FCW-1:0]        fifo_count;
    logic [PW-1:0]         fifo_wr;
    logic [PW-1:0]         fifo_rd;
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] tag_pc    [MAX_OUTSTANDING];
    logic [TW-1:0]         tag_wr;
    logic [TW-1:0]         tag_rd;

    logic [SW-1:0]         credit_used;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  req_valid;
    logic                  req_fire;
    logic                  rsp_in;
    logic                  rsp_drop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  head_valid;
    logic                  out_valid;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts buffered entries plus responses that will still land in the FIFO,
    // so a request is only issued when its response is guaranteed a slot.
    always_comb begin
        credit_used     = SW'(fifo_count) + SW'(inflight) - SW'(discard);
        redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
        req_valid       = ~rst & ~redirect_valid
                          & (SW'(inflight) < SW'(MAX_OUTSTANDING))
                          & (credit_used < SW'(FIFO_DEPTH));
        req_fire        = req_valid & bus.imem_req_ready;
        rsp_in          = bus.imem_rsp_valid & (inflight != '0);
        rsp_drop        = rsp_in & (discard != '0);
        fifo_push       = rsp_in & ~rsp_drop & ~redirect_valid;
        head_valid      = (fifo_count != '0);
        out_valid       = head_valid & ~redirect_valid;
        fifo_pop        = out_valid & bus.fd_ready;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.fd_valid       = out_valid;
    assign bus.fd_pc          = head_valid ? fifo_pc[fifo_rd] : '0;
    assign bus.fd_inst        = head_valid ? fifo_inst[fifo_rd] : '0;

    // A redirect flushes all buffered state; every response still in flight at that
    // point (including ones already marked for discard) belongs to the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            inflight   <= '0;
            discard    <= '0;
            fifo_count <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            tag_wr     <= '0;
            tag_rd     <= '0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_target;
            inflight   <= inflight - CW'(rsp_in);
            discard    <= inflight - CW'(rsp_in);
            fifo_count <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            tag_wr     <= '0;
            tag_rd     <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                tag_wr   <= tag_next(tag_wr);
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_in);
            if (rsp_drop) begin
                discard <= discard - 1'b1;
            end
            if (fifo_push) begin
                fifo_wr <= fifo_wr + 1'b1;
                tag_rd  <= tag_next(tag_rd);
            end
            if (fifo_pop) begin
                fifo_rd <= fifo_rd + 1'b1;
            end
            fifo_count <= fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (fifo_push) begin
            fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
            fifo_inst[fifo_wr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a simple instruction-memory model whose
// response latency is selectable (1 or 2 cycles after accept).
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_lat2;

    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;

    logic        cur_rst, cur_rv, cur_rr, cur_fr;
    logic [31:0] cur_rpc;

    int vectors = 0;
    int miscompares = 0;

    if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // Memory model: accepts whenever the bench raises ready, answers in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_a <= '0;
            s2_a <= '0;
        end else begin
            s1_v <= bus.imem_req_valid & bus.imem_req_ready;
            s1_a <= bus.imem_req_addr;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    assign bus.imem_rsp_valid = mem_lat2 ? s2_v : s1_v;
    assign bus.imem_rsp_data  = inst_of(mem_lat2 ? s2_a : s1_a);

    task automatic apply_stimulus(input logic r, input logic rv, input logic [31:0] rpc,
                                  input logic rr, input logic fr);
        @(posedge clk);
        #1;
        cur_rst = r; cur_rv = rv; cur_rpc = rpc; cur_rr = rr; cur_fr = fr;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.imem_req_ready = rr;
        bus.fd_ready       = fr;
        #1;
    endtask

    task automatic hold();
        apply_stimulus(cur_rst, cur_rv, cur_rpc, cur_rr, cur_fr);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next fd handshake and checks its pc/inst, then consumes it.
    task automatic wait_fd(input string tag, input logic [31:0] exp_pc, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.fd_valid === 1'b1 && cur_fr) begin
                check_output({tag, "_pc"}, bus.fd_pc, exp_pc);
                check_output({tag, "_inst"}, bus.fd_inst, inst_of(exp_pc));
                found = 1;
            end
            hold();
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s timeout observed=none expected=%h", tag, exp_pc);
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_lat2 = 1'b0;
        bus.imem_req_ready = 1'b1; bus.fd_ready = 1'b1;
        cur_rst = 1'b1; cur_rv = 1'b0; cur_rpc = '0; cur_rr = 1'b1; cur_fr = 1'b1;

        $display("[TB] test 1: reset release and streaming");
        apply_stimulus(1, 0, 0, 1, 1);
        check_output("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_output("rst_req_addr", bus.imem_req_addr, 32'h0);
        check_output("rst_fd_valid", 32'(bus.fd_valid), 32'd0);
        check_output("rst_fd_pc", bus.fd_pc, 32'h0);
        check_output("rst_fd_inst", bus.fd_inst, 32'h0);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t1_c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_output("t1_c1_req_addr", bus.imem_req_addr, 32'h0);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t1_c2_req_addr", bus.imem_req_addr, 32'h4);
        check_output("t1_c2_fd_valid", 32'(bus.fd_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 0, 1, 1);
            check_output("t1_stream_valid", 32'(bus.fd_valid), 32'd1);
            check_output("t1_stream_pc", bus.fd_pc, 32'(4 * i));
            check_output("t1_stream_inst", bus.fd_inst, inst_of(32'(4 * i)));
        end

        $display("[TB] test 2: decode stall fills the buffer");
        apply_stimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0, 1, 0);
        check_output("t2_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
        check_output("t2_req_addr_full", bus.imem_req_addr, 32'h10);
        check_output("t2_fd_valid_full", 32'(bus.fd_valid), 32'd1);
        check_output("t2_head_pc", bus.fd_pc, 32'h0);
        check_output("t2_head_inst", bus.fd_inst, inst_of(32'h0));
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 0, 1, 1);
            check_output("t2_drain_valid", 32'(bus.fd_valid), 32'd1);
            check_output("t2_drain_pc", bus.fd_pc, 32'(4 * i));
        end

        $display("[TB] test 3: redirect with two requests in flight");
        mem_lat2 = 1'b1;
        apply_stimulus(1, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 1);
        apply_stimulus(0, 1, 32'h103, 1, 1);
        check_output("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_output("t3_redir_fd_valid", 32'(bus.fd_valid), 32'd0);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t3_resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_output("t3_resume_addr", bus.imem_req_addr, 32'h100);
        wait_fd("t3_first", 32'h100, 12);
        wait_fd("t3_second", 32'h104, 12);

        $display("[TB] test 4: memory backpressure");
        mem_lat2 = 1'b0;
        apply_stimulus(1, 0, 0, 1, 1);
        apply_stimulus(0, 1, 32'h20, 0, 1);
        check_output("t4_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 0, 0, 1);
            check_output("t4_stall_valid", 32'(bus.imem_req_valid), 32'd1);
            check_output("t4_stall_addr", bus.imem_req_addr, 32'h20);
        end
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t4_accept_addr", bus.imem_req_addr, 32'h20);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t4_next_addr", bus.imem_req_addr, 32'h24);
        wait_fd("t4_first", 32'h20, 10);
        wait_fd("t4_second", 32'h24, 10);

        $display("[TB] test 5: redirect, response and fd_ready together");
        apply_stimulus(1, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 1, 1);
        apply_stimulus(0, 1, 32'h200, 1, 1);
        check_output("t5_redir_fd_valid", 32'(bus.fd_valid), 32'd0);
        check_output("t5_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t5_after_fd_valid", 32'(bus.fd_valid), 32'd0);
        check_output("t5_after_addr", bus.imem_req_addr, 32'h200);
        wait_fd("t5_first", 32'h200, 10);
        wait_fd("t5_second", 32'h204, 10);

        $display("[TB] test 6: reset mid-stream");
        apply_stimulus(1, 0, 0, 1, 1);
        check_output("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        apply_stimulus(0, 0, 0, 1, 1);
        check_output("t6_fd_valid", 32'(bus.fd_valid), 32'd0);
        check_output("t6_req_addr", bus.imem_req_addr, 32'h0);
        check_output("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        wait_fd("t6_first", 32'h0, 10);
        wait_fd("t6_second", 32'h4, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
